// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   Registered instruction-decode stage for a pipelined B32P-class CPU.
//   Takes instructions from fetch over a valid/ready handshake. It decodes the
//   4-bit opcode (top nibble of the instruction) into a 14-bit control bundle.
//   It presents instruction, PC and control to execute one cycle later.
//   The stage also provides:
//     - output backpressure
//     - flush
//     - a HALT wait state that an interrupt wakes up
//     - a count of accepted instructions
//
// Optional feature macro: ILLEGAL_OP_TRAP_EN
//   Defined   : accepting opcode 3 or 2 pulses illegal_op for the first cycle
//               the instruction is presented on out_*.
//   Undefined : illegal_op is tied low, and opcodes 3/2 decode as silent NOPs.
//
// Ports
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   in_valid     in   fetch presents an instruction
//   in_instr     in   instruction word (INSTR_W)
//   in_pc        in   PC of in_instr (ADDR_W)
//   in_ready     out  stage can accept this cycle (combinational)
//   out_valid    out  out_* holds a decoded instruction
//   out_ready    in   execute accepts out_*
//   out_instr    out  registered instruction
//   out_pc       out  registered PC
//   out_ctrl     out  control bundle:
//                       [0]  alu_use_const   [1]  push      [2]  pop
//                       [3]  dreg_we         [4]  mem_write [5]  mem_read
//                       [6]  jumpc           [7]  jumpr     [8]  branch
//                       [9]  halt            [10] reti      [11] getIntID
//                       [12] getPC           [13] clearCache
//   flush        in   discard the held instruction and the incoming one
//   irq          in   level interrupt request; wakes the HALTED state
//   halted       out  stage is in the HALTED state
//   illegal_op   out  one-cycle pulse on an undefined opcode (feature only)
//   instr_count  out  accepted-instruction count, wraps (CNT_W)
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 27,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_pc,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [13:0]        out_ctrl,
    input  logic               flush,
    input  logic               irq,
    output logic               halted,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   instr_count
);

    // Control bundle bit positions
    localparam int C_ALU_CONST = 0;
    localparam int C_PUSH      = 1;
    localparam int C_POP       = 2;
    localparam int C_DREG_WE   = 3;
    localparam int C_MEM_WRITE = 4;
    localparam int C_MEM_READ  = 5;
    localparam int C_JUMPC     = 6;
    localparam int C_JUMPR     = 7;
    localparam int C_BRANCH    = 8;
    localparam int C_HALT      = 9;
    localparam int C_RETI      = 10;
    localparam int C_GETINTID  = 11;
    localparam int C_GETPC     = 12;
    localparam int C_CLRCACHE  = 13;

    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    // Opcode to control-bundle decode.
    // Opcodes 3 and 2 are undefined and decode as an all-zero NOP.
    function automatic logic [13:0] f_decode(input logic [3:0] op);
        logic [13:0] c;
        c = 14'd0;
        case (op)
            4'hF: c[C_HALT] = 1'b1;
            4'hE: begin c[C_MEM_READ] = 1'b1; c[C_DREG_WE] = 1'b1; end
            4'hD: c[C_MEM_WRITE] = 1'b1;
            4'hC: begin c[C_GETINTID] = 1'b1; c[C_DREG_WE] = 1'b1; end
            4'hB: c[C_PUSH] = 1'b1;
            4'hA: begin c[C_POP] = 1'b1; c[C_DREG_WE] = 1'b1; end
            4'h9: c[C_JUMPC] = 1'b1;
            4'h8: c[C_JUMPR] = 1'b1;
            4'h7: c[C_CLRCACHE] = 1'b1;
            4'h6: c[C_BRANCH] = 1'b1;
            4'h5: begin c[C_GETPC] = 1'b1; c[C_DREG_WE] = 1'b1; end
            4'h4: c[C_RETI] = 1'b1;
            4'h1: begin c[C_ALU_CONST] = 1'b1; c[C_DREG_WE] = 1'b1; end
            4'h0: c[C_DREG_WE] = 1'b1;
            default: c = 14'd0;
        endcase
        return c;
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_in_ready;
    logic                 w_transfer;
    logic [3:0]           w_opcode;
    logic                 r_out_valid;
    logic [INSTR_W-1:0]   r_out_instr;
    logic [ADDR_W-1:0]    r_out_pc;
    logic [13:0]          r_out_ctrl;
    logic [CNT_W-1:0]     r_instr_count;

    assign w_opcode   = in_instr[INSTR_W-1 -: 4];
    // w_in_ready already excludes flush, so a flush always blocks the capture.
    assign w_transfer = in_valid && w_in_ready;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state.
    // Accepting a HALT parks the stage in HALTED.
    // While HALTED, only irq leaves the state; flush alone does not.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_transfer && (w_opcode == OP_HALT)) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (irq) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_HALTED;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // FSM outputs.
    // The stage accepts only in RUN, and only when the output slot is free
    // or is being drained this cycle.
    always_comb begin
        w_in_ready = 1'b0;
        halted     = 1'b0;
        if (reset || flush) begin
            w_in_ready = 1'b0;
        end else if (r_state == ST_RUN) begin
            w_in_ready = !r_out_valid || out_ready;
        end else begin
            w_in_ready = 1'b0;
        end
        if (r_state == ST_HALTED) begin
            halted = 1'b1;
        end else begin
            halted = 1'b0;
        end
    end

    // Output data registers.
    // They load only on a transfer; otherwise they hold bit-exact.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_instr <= {INSTR_W{1'b0}};
            r_out_pc    <= {ADDR_W{1'b0}};
            r_out_ctrl  <= 14'd0;
        end else if (w_transfer) begin
            r_out_instr <= in_instr;
            r_out_pc    <= in_pc;
            r_out_ctrl  <= f_decode(w_opcode);
        end
    end

    // Output valid flag.
    // Flush wins over everything. A drain with no refill empties the slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_transfer) begin
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Accepted-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_count <= {CNT_W{1'b0}};
        end else if (w_transfer) begin
            r_instr_count <= r_instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic r_illegal_op;

    // Undefined-opcode trap.
    // Loaded at the same edge as out_valid, so the pulse lines up with the
    // first presentation of the instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal_op <= 1'b0;
        end else begin
            r_illegal_op <= w_transfer && ((w_opcode == 4'h3) || (w_opcode == 4'h2));
        end
    end

    assign illegal_op = r_illegal_op;
`else
    assign illegal_op = 1'b0;
`endif

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign out_instr   = r_out_instr;
    assign out_pc      = r_out_pc;
    assign out_ctrl    = r_out_ctrl;
    assign instr_count = r_instr_count;

endmodule
